// File: rtl/video_timing_pkg.sv
// -----------------------------------------------------------------------------
// video_timing_pkg
// Shared types and helpers for the raster timing generator.
//   state_t   : run/stop controller states (IDLE, RUN, DRAIN)
//   H_TOT     : total pixels per line for the default 1080p60 timing
//   V_TOT     : total lines per frame for the default 1080p60 timing
//   cnt_width : bit width needed for a counter spanning 0..total-1
// -----------------------------------------------------------------------------
package video_timing_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int H_TOT = 1920 + 88 + 44 + 148;
  localparam int V_TOT = 1080 + 4 + 5 + 36;

  // A counter always needs at least one bit, even for a degenerate total of 1.
  function automatic int cnt_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/timing_axis_cnt.sv
// -----------------------------------------------------------------------------
// timing_axis_cnt
// Wrap-around counter for one raster axis (0..MAX, then back to 0).
//   in_pclk : pixel clock
//   in_rst  : synchronous active-high reset
//   clr     : synchronous clear to 0 (dominates en)
//   en      : advance by one (or wrap) this cycle
//   cnt     : current count
//   tc      : terminal count, high while cnt == MAX
// -----------------------------------------------------------------------------
module timing_axis_cnt #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input  logic             in_pclk,
  input  logic             in_rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  assign tc = (cnt == MAX_V);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge in_pclk) begin
    if (in_rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
// Raster timing generator feeding the test-pattern / datapack stage. Each
// clock carries PACK_NUM pixels. A run/stop controller only starts and stops
// on frame boundaries so downstream never sees a partial frame.
//   in_pclk         : pixel clock (only clock)
//   in_rst          : synchronous active-high reset
//   in_run          : level request to generate frames
//   out_x / out_y   : first pixel index of the pack / active line (0 if blank)
//   out_valid/out_de: pack carries active pixels
//   out_hs / out_vs : syncs, polarity set by HS_POL / VS_POL
//   out_frame_start : one-cycle pulse with the pack at (0,0)
//   out_frame_cnt   : completed frames, wraps 255 -> 0
// All outputs are registered one cycle after the counter state they decode.
// -----------------------------------------------------------------------------
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int FIFO_WIDTH   = 11,
  parameter int PACK_NUM     = 2,
  parameter int H_ActivePix  = 1920,
  parameter int H_FrontPorch = 88,
  parameter int H_SyncPulse  = 44,
  parameter int H_BackPorch  = 148,
  parameter int V_ActivePix  = 1080,
  parameter int V_FrontPorch = 4,
  parameter int V_SyncPulse  = 5,
  parameter int V_BackPorch  = 36,
  parameter bit HS_POL       = 1'b1,
  parameter bit VS_POL       = 1'b1
) (
  input  logic                  in_pclk,
  input  logic                  in_rst,
  input  logic                  in_run,
  output logic [FIFO_WIDTH-1:0] out_x,
  output logic [FIFO_WIDTH-1:0] out_y,
  output logic                  out_valid,
  output logic                  out_de,
  output logic                  out_hs,
  output logic                  out_vs,
  output logic                  out_frame_start,
  output logic [7:0]            out_frame_cnt
);

  // ---------------------------------------------------------------------------
  // Derived geometry (horizontal values in packs, vertical in lines)
  // ---------------------------------------------------------------------------
  localparam int H_TOTAL_PK = (H_ActivePix + H_FrontPorch + H_SyncPulse + H_BackPorch) / PACK_NUM;
  localparam int V_TOTAL    = V_ActivePix + V_FrontPorch + V_SyncPulse + V_BackPorch;
  localparam int H_W        = cnt_width(H_TOTAL_PK);
  localparam int V_W        = cnt_width(V_TOTAL);

  // Region bounds are one bit wider than the counters: an end bound may equal
  // the axis total when the following porch is zero.
  localparam logic [H_W:0] H_ACT_END  = (H_W+1)'(H_ActivePix / PACK_NUM);
  localparam logic [H_W:0] H_SYNC_BEG = (H_W+1)'((H_ActivePix + H_FrontPorch) / PACK_NUM);
  localparam logic [H_W:0] H_SYNC_END = (H_W+1)'((H_ActivePix + H_FrontPorch + H_SyncPulse) / PACK_NUM);
  localparam logic [V_W:0] V_ACT_END  = (V_W+1)'(V_ActivePix);
  localparam logic [V_W:0] V_SYNC_BEG = (V_W+1)'(V_ActivePix + V_FrontPorch);
  localparam logic [V_W:0] V_SYNC_END = (V_W+1)'(V_ActivePix + V_FrontPorch + V_SyncPulse);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if ((H_ActivePix  % PACK_NUM) != 0 || (H_FrontPorch % PACK_NUM) != 0 ||
      (H_SyncPulse  % PACK_NUM) != 0 || (H_BackPorch  % PACK_NUM) != 0) begin : g_bad_pack
    $error("video_timing_gen: horizontal timing not divisible by PACK_NUM");
  end

  if (H_ActivePix >= (1 << FIFO_WIDTH) || V_ActivePix >= (1 << FIFO_WIDTH)) begin : g_bad_width
    $error("video_timing_gen: active size does not fit in FIFO_WIDTH");
  end

  // ---------------------------------------------------------------------------
  // Run request register and run/stop controller
  // ---------------------------------------------------------------------------
  state_t         state;
  state_t         state_nxt;
  logic           run_q;
  logic           cnt_en;
  logic           cnt_clr;
  logic           frame_end;
  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic           h_tc;
  logic           v_tc;
  logic           v_en;

  always_ff @(posedge in_pclk) begin
    if (in_rst) begin
      run_q <= 1'b0;
      state <= IDLE;
    end else begin
      run_q <= in_run;
      state <= state_nxt;
    end
  end

  assign cnt_en    = (state != IDLE);
  assign cnt_clr   = (state == IDLE);
  assign frame_end = cnt_en && h_tc && v_tc;
  assign v_en      = cnt_en && h_tc;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (run_q) state_nxt = RUN;
      end
      RUN: begin
        // A stop request landing on the last pack of a frame ends right there
        // rather than draining an entire extra frame.
        if (!run_q) state_nxt = frame_end ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (run_q)          state_nxt = RUN;
        else if (frame_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Raster counters: h wraps once per line, v advances on each h wrap
  // ---------------------------------------------------------------------------
  timing_axis_cnt #(
    .WIDTH (H_W),
    .MAX   (H_TOTAL_PK - 1)
  ) u_h_cnt (
    .in_pclk (in_pclk),
    .in_rst  (in_rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .cnt     (h_cnt),
    .tc      (h_tc)
  );

  timing_axis_cnt #(
    .WIDTH (V_W),
    .MAX   (V_TOTAL - 1)
  ) u_v_cnt (
    .in_pclk (in_pclk),
    .in_rst  (in_rst),
    .clr     (cnt_clr),
    .en      (v_en),
    .cnt     (v_cnt),
    .tc      (v_tc)
  );

  // ---------------------------------------------------------------------------
  // Region decode. Everything is gated by cnt_en so IDLE stays quiet. vs only
  // depends on v, which only moves on an h wrap, so vs edges land at h = 0.
  // ---------------------------------------------------------------------------
  logic active;
  logic hs_on;
  logic vs_on;
  logic at_origin;

  always_comb begin
    active    = 1'b0;
    hs_on     = 1'b0;
    vs_on     = 1'b0;
    at_origin = 1'b0;
    if (cnt_en) begin
      active    = ({1'b0, h_cnt} < H_ACT_END) && ({1'b0, v_cnt} < V_ACT_END);
      hs_on     = ({1'b0, h_cnt} >= H_SYNC_BEG) && ({1'b0, h_cnt} < H_SYNC_END);
      vs_on     = ({1'b0, v_cnt} >= V_SYNC_BEG) && ({1'b0, v_cnt} < V_SYNC_END);
      at_origin = (h_cnt == '0) && (v_cnt == '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge in_pclk) begin
    if (in_rst) begin
      out_x           <= '0;
      out_y           <= '0;
      out_valid       <= 1'b0;
      out_hs          <= ~HS_POL;
      out_vs          <= ~VS_POL;
      out_frame_start <= 1'b0;
      out_frame_cnt   <= '0;
    end else begin
      out_x           <= active ? FIFO_WIDTH'(h_cnt) * FIFO_WIDTH'(PACK_NUM) : '0;
      out_y           <= active ? FIFO_WIDTH'(v_cnt) : '0;
      out_valid       <= active;
      out_hs          <= hs_on ? HS_POL : ~HS_POL;
      out_vs          <= vs_on ? VS_POL : ~VS_POL;
      out_frame_start <= active && at_origin;
      if (frame_end) out_frame_cnt <= out_frame_cnt + 8'd1;
    end
  end

  assign out_de = out_valid;

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
// Directed bench for video_timing_gen with PACK_NUM=2, H 8/2/2/4 (8 clocks per
// line) and V 4/1/1/2 (8 lines, 64 clocks per frame). A second instance with
// inverted sync polarity runs on the same stimulus.
// Expected raster, frame position p = 0..63: line = p/8, col = p%8;
// active when line<4 and col<4 (x = 2*col, y = line); hs on col 5; vs on line 5.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;

  logic [10:0] x0, y0, x1, y1;
  logic        valid0, de0, hs0, vs0, fs0;
  logic        valid1, de1, hs1, vs1, fs1;
  logic [7:0]  cnt0, cnt1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .FIFO_WIDTH(11), .PACK_NUM(2),
    .H_ActivePix(8), .H_FrontPorch(2), .H_SyncPulse(2), .H_BackPorch(4),
    .V_ActivePix(4), .V_FrontPorch(1), .V_SyncPulse(1), .V_BackPorch(2),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_dut_pos (
    .in_pclk(clk), .in_rst(rst), .in_run(run),
    .out_x(x0), .out_y(y0), .out_valid(valid0), .out_de(de0),
    .out_hs(hs0), .out_vs(vs0), .out_frame_start(fs0), .out_frame_cnt(cnt0)
  );

  video_timing_gen #(
    .FIFO_WIDTH(11), .PACK_NUM(2),
    .H_ActivePix(8), .H_FrontPorch(2), .H_SyncPulse(2), .H_BackPorch(4),
    .V_ActivePix(4), .V_FrontPorch(1), .V_SyncPulse(1), .V_BackPorch(2),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_dut_neg (
    .in_pclk(clk), .in_rst(rst), .in_run(run),
    .out_x(x1), .out_y(y1), .out_valid(valid1), .out_de(de1),
    .out_hs(hs1), .out_vs(vs1), .out_frame_start(fs1), .out_frame_cnt(cnt1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // All outputs quiet (reset / idle levels), with the given frame count.
  task automatic chk_quiet(input string tag, input int fcnt);
    check({tag, ".x"},      32'(x0),     32'd0);
    check({tag, ".y"},      32'(y0),     32'd0);
    check({tag, ".valid"},  32'(valid0), 32'd0);
    check({tag, ".de"},     32'(de0),    32'd0);
    check({tag, ".fs"},     32'(fs0),    32'd0);
    check({tag, ".hs"},     32'(hs0),    32'd0);
    check({tag, ".vs"},     32'(vs0),    32'd0);
    check({tag, ".cnt"},    32'(cnt0),   32'(fcnt));
    check({tag, ".hs_n"},   32'(hs1),    32'd1);
    check({tag, ".vs_n"},   32'(vs1),    32'd1);
    check({tag, ".de_n"},   32'(de1),    32'd0);
  endtask

  // Outputs for running frame position k (k counts packs since start).
  task automatic chk_pos(input string tag, input int k, input int fcnt);
    int  p, line, col;
    bit  e_de, e_hs, e_vs;
    p    = k % 64;
    line = p / 8;
    col  = p % 8;
    e_de = (line < 4) && (col < 4);
    e_hs = (col == 5);
    e_vs = (line == 5);
    check($sformatf("%s.de@%0d", tag, k),    32'(de0),    32'(e_de));
    check($sformatf("%s.valid@%0d", tag, k), 32'(valid0), 32'(e_de));
    check($sformatf("%s.x@%0d", tag, k),     32'(x0),     e_de ? 32'(2 * col) : 32'd0);
    check($sformatf("%s.y@%0d", tag, k),     32'(y0),     e_de ? 32'(line) : 32'd0);
    check($sformatf("%s.hs@%0d", tag, k),    32'(hs0),    32'(e_hs));
    check($sformatf("%s.vs@%0d", tag, k),    32'(vs0),    32'(e_vs));
    check($sformatf("%s.fs@%0d", tag, k),    32'(fs0),    32'(p == 0));
    check($sformatf("%s.cnt@%0d", tag, k),   32'(cnt0),   32'(fcnt & 255));
    check($sformatf("%s.hs_n@%0d", tag, k),  32'(hs1),    32'(!e_hs));
    check($sformatf("%s.vs_n@%0d", tag, k),  32'(vs1),    32'(!e_vs));
    check($sformatf("%s.de_n@%0d", tag, k),  32'(de1),    32'(e_de));
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;

    // Reset values
    tick();
    tick();
    chk_quiet("reset", 0);
    rst = 1'b0;

    // Idle with run low: stays quiet
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_quiet("idle", 0);
    end

    // Start: run sampled at edge N, first active pack at N+2
    run = 1'b1;
    tick();
    chk_quiet("start_n", 0);
    tick();
    chk_quiet("start_n1", 0);

    // Three frames; run drops at cycle 10 of the third, which still completes
    for (int k = 0; k < 192; k++) begin
      tick();
      chk_pos("run", k, (k + 1) / 64);
      if (k == 128 + 9) run = 1'b0;
    end

    // Drained: quiet afterwards
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_quiet("drained", 3);
    end

    // Restart, drop run early, re-assert during drain: seamless next frame
    run = 1'b1;
    tick();
    chk_quiet("restart_n", 3);
    tick();
    chk_quiet("restart_n1", 3);
    for (int k = 0; k < 95; k++) begin
      tick();
      chk_pos("redrain", k, 3 + (k + 1) / 64);
      if (k == 9)  run = 1'b0;
      if (k == 30) run = 1'b1;
    end

    // Reset at frame cycle 31 of the second frame, run held high
    rst = 1'b1;
    tick();
    chk_quiet("mid_rst", 0);
    rst = 1'b0;
    tick();
    chk_quiet("post_rst1", 0);
    tick();
    chk_quiet("post_rst2", 0);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk_pos("after_rst", k, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
